// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 80;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_VALID,
    output logic              in_READY,
    input  logic [DATA_W-1:0] in_DATA,
    input  logic              FLUSH,
    output logic              out_VALID,
    input  logic              out_READY,
    output logic [DATA_W-1:0] out_DATA,
    input  logic              clr_CNT,
    output logic [CNT_W-1:0]  stall_CNT
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept;
    logic              emit;

    assign out_VALID = (state_q != ST_EMPTY);
    assign out_DATA  = main_q;
    assign accept    = in_VALID & in_READY;
    assign emit      = out_VALID & out_READY;

    // Registered ready with skid entry, or single register with ready fed through.
    generate
        if (SKID) begin : g_ready_reg
            assign in_READY = (state_q != ST_SKID);
        end else begin : g_ready_comb
            assign in_READY = out_READY | ~out_VALID;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_DATA;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (emit && accept) begin
                    main_d = in_DATA;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end else if (accept && SKID) begin
                    skid_d  = in_DATA;
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_READY) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush squashes held beats and any beat taken this cycle; data regs keep contents.
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (out_VALID & ~out_READY),
        .clr   (clr_CNT),
        .count (stall_CNT)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: one skid-mode stage (16-bit counter) and one single-register
// stage (5-bit counter so saturation is reached quickly).
module tb_pipe_skid_reg;

    logic        CLK;
    logic        RESET;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_clr;
    logic [79:0] a_in_data, a_out_data;
    logic [15:0] a_cnt;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_clr;
    logic [79:0] b_in_data, b_out_data;
    logic [4:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.DATA_W(80), .SKID(1'b1), .CNT_W(16)) u_skid (
        .CLK(CLK), .RESET(RESET),
        .in_VALID(a_in_valid), .in_READY(a_in_ready), .in_DATA(a_in_data),
        .FLUSH(a_flush),
        .out_VALID(a_out_valid), .out_READY(a_out_ready), .out_DATA(a_out_data),
        .clr_CNT(a_clr), .stall_CNT(a_cnt)
    );

    pipe_skid_reg #(.DATA_W(80), .SKID(1'b0), .CNT_W(5)) u_noskid (
        .CLK(CLK), .RESET(RESET),
        .in_VALID(b_in_valid), .in_READY(b_in_ready), .in_DATA(b_in_data),
        .FLUSH(b_flush),
        .out_VALID(b_out_valid), .out_READY(b_out_ready), .out_DATA(b_out_data),
        .clr_CNT(b_clr), .stall_CNT(b_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_flush = 0; a_out_ready = 0; a_clr = 0;
        b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 0; b_clr = 0;
        repeat (2) cyc();
        RESET = 1'b0;
        #1;
        chk("rst_a_vld", 80'(a_out_valid), 80'd0);
        chk("rst_a_rdy", 80'(a_in_ready), 80'd1);
        chk("rst_a_dat", a_out_data, 80'd0);
        chk("rst_a_cnt", 80'(a_cnt), 80'd0);
        chk("rst_b_vld", 80'(b_out_valid), 80'd0);
        chk("rst_b_cnt", 80'(b_cnt), 80'd0);
        cyc();

        // Full-rate stream with one-cycle latency
        a_out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1; a_in_data = 80'(i);
            #1;
            chk("strm_rdy", 80'(a_in_ready), 80'd1);
            if (i == 1) begin
                chk("strm_vld0", 80'(a_out_valid), 80'd0);
            end else begin
                chk("strm_vld", 80'(a_out_valid), 80'd1);
                chk("strm_dat", a_out_data, 80'(i - 1));
            end
            cyc();
        end
        a_in_valid = 0;
        #1;
        chk("strm_last", a_out_data, 80'h8);
        cyc();
        chk("strm_drain", 80'(a_out_valid), 80'd0);
        chk("strm_cnt", 80'(a_cnt), 80'd0);

        // Back-pressure into skid entry
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 80'hA;
        #1;
        chk("bp_rdyA", 80'(a_in_ready), 80'd1);
        cyc();
        a_in_data = 80'hB;
        #1;
        chk("bp_rdyB", 80'(a_in_ready), 80'd1);
        chk("bp_datA", a_out_data, 80'hA);
        chk("bp_cnt0", 80'(a_cnt), 80'd0);
        cyc();
        a_in_valid = 0;
        #1;
        chk("bp_skid_rdy", 80'(a_in_ready), 80'd0);
        chk("bp_skid_vld", 80'(a_out_valid), 80'd1);
        chk("bp_skid_dat", a_out_data, 80'hA);
        chk("bp_cnt1", 80'(a_cnt), 80'd1);
        cyc();
        chk("bp_cnt2", 80'(a_cnt), 80'd2);
        chk("bp_stable", a_out_data, 80'hA);
        cyc();
        a_out_ready = 1;
        #1;
        chk("rel_datA", a_out_data, 80'hA);
        chk("rel_cnt3", 80'(a_cnt), 80'd3);
        cyc();
        chk("rel_datB", a_out_data, 80'hB);
        chk("rel_vldB", 80'(a_out_valid), 80'd1);
        chk("rel_rdy", 80'(a_in_ready), 80'd1);
        cyc();
        chk("rel_empty", 80'(a_out_valid), 80'd0);
        chk("rel_cnt", 80'(a_cnt), 80'd3);

        // Flush while in skid state with a beat offered
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 80'h11;
        cyc();
        a_in_data = 80'h12;
        cyc();
        a_in_data = 80'h13; a_flush = 1;
        #1;
        chk("fl_pre_rdy", 80'(a_in_ready), 80'd0);
        cyc();
        a_flush = 0; a_in_valid = 0;
        #1;
        chk("fl_vld", 80'(a_out_valid), 80'd0);
        chk("fl_rdy", 80'(a_in_ready), 80'd1);
        chk("fl_cnt", 80'(a_cnt), 80'd5);
        a_out_ready = 1;
        cyc();
        chk("fl_noemit1", 80'(a_out_valid), 80'd0);
        cyc();
        chk("fl_noemit2", 80'(a_out_valid), 80'd0);

        // Flush drops a beat accepted in the same cycle
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 80'h21;
        cyc();
        a_in_data = 80'h22; a_flush = 1;
        #1;
        chk("fl2_rdy", 80'(a_in_ready), 80'd1);
        cyc();
        a_flush = 0; a_in_valid = 0;
        #1;
        chk("fl2_vld", 80'(a_out_valid), 80'd0);
        chk("fl2_rdy_after", 80'(a_in_ready), 80'd1);
        chk("fl2_cnt", 80'(a_cnt), 80'd6);
        a_clr = 1;
        cyc();
        a_clr = 0;
        chk("clr_a", 80'(a_cnt), 80'd0);

        // Asynchronous reset while holding two beats
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 80'h31;
        cyc();
        a_in_data = 80'h32;
        cyc();
        a_in_valid = 0;
        #1;
        chk("ar_pre_dat", a_out_data, 80'h31);
        chk("ar_pre_rdy", 80'(a_in_ready), 80'd0);
        chk("ar_pre_cnt", 80'(a_cnt), 80'd1);
        RESET = 1;
        #1;
        chk("ar_vld", 80'(a_out_valid), 80'd0);
        chk("ar_dat", a_out_data, 80'd0);
        chk("ar_cnt", 80'(a_cnt), 80'd0);
        chk("ar_rdy", 80'(a_in_ready), 80'd1);
        #1;
        RESET = 0;
        cyc();
        chk("ar_post_vld", 80'(a_out_valid), 80'd0);

        // Single-register mode: ready follows out_READY combinationally
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 80'h41;
        #1;
        chk("ns_rdy_empty", 80'(b_in_ready), 80'd1);
        cyc();
        b_in_data = 80'h42;
        #1;
        chk("ns_rdy_blk", 80'(b_in_ready), 80'd0);
        chk("ns_dat41", b_out_data, 80'h41);
        cyc();
        chk("ns_hold41", b_out_data, 80'h41);
        chk("ns_cnt1", 80'(b_cnt), 80'd1);
        b_out_ready = 1;
        #1;
        chk("ns_rdy_comb", 80'(b_in_ready), 80'd1);
        cyc();
        chk("ns_dat42", b_out_data, 80'h42);
        for (int i = 3; i <= 5; i++) begin
            b_in_data = 80'(8'h40 + i);
            #1;
            chk("ns_strm_rdy", 80'(b_in_ready), 80'd1);
            cyc();
            chk("ns_strm_dat", b_out_data, 80'(8'h40 + i));
        end
        b_in_valid = 0;
        cyc();
        chk("ns_drain", 80'(b_out_valid), 80'd0);
        chk("ns_cnt", 80'(b_cnt), 80'd1);

        // Counter saturation and clear during an ongoing stall
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 80'h50;
        cyc();
        b_in_valid = 0;
        repeat (40) cyc();
        chk("sat_cnt", 80'(b_cnt), 80'h1F);
        chk("sat_dat", b_out_data, 80'h50);
        b_clr = 1;
        cyc();
        b_clr = 0;
        chk("sat_clr", 80'(b_cnt), 80'd0);
        cyc();
        chk("sat_resume", 80'(b_cnt), 80'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
